uart_dbg_master: RTL and testbench
==================================

UART_DBG_MASTER -- requirements
Module: uart_dbg_master

Interface
REQ-001 SHALL have parameter IDLE_ADDR, default 32'hFFFFFFFF: value driven on addr_b when no bus access is in progress.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 255: read-wait limit, used only under REQ-031.
REQ-003 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port rx_valid, input, 1: one-cycle pulse; received UART byte present on rx_data.
REQ-006 SHALL have port rx_data, input, 8: received byte; sampled only when rx_valid=1.
REQ-007 SHALL have port tx_busy, input, 1: UART transmitter busy; no new byte is accepted while high.
REQ-008 SHALL have port tx_wr, output, 1: one-cycle pulse that hands tx_data to the transmitter.
REQ-009 SHALL have port tx_data, output, 8: byte to transmit; valid while tx_wr=1.
REQ-010 SHALL have port addr_b, output, 32: bus address.
REQ-011 SHALL have port data_b_out, output, 32: bus write data, connected to peripheral data_b_in.
REQ-012 SHALL have port data_b_we, output, 1: bus write enable.
REQ-013 SHALL have port data_b_in, input, 32: bus read data returned by the peripheral.
REQ-014 SHALL have port strobe_b, input, 1: peripheral read-data-valid.
REQ-015 SHALL have port busy, output, 1: high whenever the state is not IDLE.

Function
REQ-016 SHALL implement the states IDLE, ADDR, DATA, WRITE, RWAIT, SEND and ACK.
REQ-017 SHALL, in IDLE on rx_valid: 0x57 'W' -> ADDR (write); 0x52 'R' -> ADDR (read); any other byte -> ACK with reply 0x3F '?'.
REQ-018 SHALL, in ADDR, shift 4 rx bytes MSB-first into the address register, then go to DATA (write) or RWAIT (read).
REQ-019 SHALL, in DATA, shift 4 rx bytes MSB-first into the data register, then go to WRITE.
REQ-020 SHALL, in WRITE, drive addr_b=address, data_b_out=data and data_b_we=1 for exactly one cycle, then go to ACK with reply 0x4B 'K'.
REQ-021 SHALL, in RWAIT, hold addr_b=address with data_b_we=0 until strobe_b=1, latch data_b_in in that same cycle, and go to SEND in the next cycle.
REQ-022 SHALL, in SEND, transmit the latched word as 4 bytes MSB-first, then return to IDLE.
REQ-023 SHALL, in ACK, transmit the single reply byte, then return to IDLE.
REQ-024 SHALL drive addr_b=IDLE_ADDR, data_b_we=0 and data_b_out=0 in every cycle outside WRITE and RWAIT.
REQ-025 SHALL assert tx_wr only when tx_busy=0, and SHALL NOT assert tx_wr in the cycle immediately after a tx_wr pulse.
REQ-026 SHALL drop rx_valid bytes that arrive in WRITE, RWAIT, SEND or ACK, with no state change.
REQ-027 SHALL ignore strobe_b outside RWAIT.
REQ-028 SHALL complete a write within 1 cycle of the last data byte; read bus latency is unbounded unless REQ-031 applies.

Reset
REQ-029 SHALL, while rst=1, force state IDLE and outputs tx_wr=0, tx_data=0, addr_b=IDLE_ADDR, data_b_out=0, data_b_we=0, busy=0.
REQ-030 SHALL, on reset mid-command, discard the partial command and shift registers with no bus access or reply; reset has priority over all events.

Configuration
REQ-031 SHALL, when UART_DBG_TIMEOUT_EN is defined: count RWAIT cycles; if TIMEOUT_CYCLES cycles elapse with strobe_b=0, leave RWAIT, return addr_b to IDLE_ADDR and go to ACK with reply 0xEE instead of SEND; a strobe_b arriving on the final counted cycle wins.
REQ-032 SHALL, when UART_DBG_TIMEOUT_EN is undefined, wait in RWAIT indefinitely and never emit 0xEE.

Verification
REQ-033 SHALL cover: rx bytes 57 00 01 00 04 00 00 00 A5 -> one cycle with addr_b=0x00010004, data_b_out=0x000000A5, data_b_we=1; then tx byte 4B.
REQ-034 SHALL cover: rx bytes 52 00 00 00 10, model returns strobe_b=1 with data_b_in=0xDEADBEEF 2 cycles later -> tx bytes DE AD BE EF in order.
REQ-035 SHALL cover: rx byte 41 -> tx byte 3F, no bus activity, busy returns to 0.
REQ-036 SHALL cover: tx_busy held high for 50 cycles during SEND -> no tx_wr while high; all 4 bytes still sent in order.
REQ-037 SHALL cover: rst pulsed after 2 address bytes -> no bus access or tx; a following full 'R' command executes normally.
REQ-038 SHALL cover, with UART_DBG_TIMEOUT_EN and TIMEOUT_CYCLES=16: read command with strobe_b held 0 -> addr_b returns to IDLE_ADDR after 16 cycles and tx byte EE.

Source files
------------

// File: rtl/uart_dbg_master.sv
// UART-driven debug bus master: 'W' addr[4] data[4] writes a word, 'R' addr[4] reads one back.
// Optional read timeout (reply 0xEE) is enabled by defining UART_DBG_TIMEOUT_EN.
module uart_dbg_master #(
  parameter logic [31:0] IDLE_ADDR      = 32'hFFFFFFFF,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  input  logic        tx_busy,
  output logic        tx_wr,
  output logic [7:0]  tx_data,
  output logic [31:0] addr_b,
  output logic [31:0] data_b_out,
  output logic        data_b_we,
  input  logic [31:0] data_b_in,
  input  logic        strobe_b,
  output logic        busy
);

  localparam logic [7:0] CMD_WRITE  = 8'h57;
  localparam logic [7:0] CMD_READ   = 8'h52;
  localparam logic [7:0] REPLY_OK   = 8'h4B;
  localparam logic [7:0] REPLY_BAD  = 8'h3F;
  localparam logic [7:0] REPLY_TOUT = 8'hEE;

`ifdef UART_DBG_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    DATA,
    WRITE,
    RWAIT,
    SEND,
    ACK
  } state_t;

  state_t      state, state_next;
  logic        is_write;
  logic [31:0] addr_reg;
  logic [31:0] data_reg;
  logic [31:0] rd_word;
  logic [1:0]  byte_cnt;
  logic [7:0]  reply;
  logic        tx_gap;
  logic [31:0] tcnt;

  logic        start_cmd, start_write;
  logic        shift_addr, shift_data, latch_rd;
  logic        load_reply;
  logic [7:0]  reply_next;
  logic        cnt_clr, cnt_inc;
  logic        tx_ok, timeout_hit;
  logic        tx_wr_c;
  logic [7:0]  tx_data_c;
  logic [31:0] addr_c, dout_c;
  logic        we_c;

  // tx_gap blocks a second tx_wr in the cycle right after a pulse
  assign tx_ok       = !tx_busy && !tx_gap;
  assign timeout_hit = TIMEOUT_EN && (tcnt == (TIMEOUT_CYCLES - 32'd1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next  = state;
    start_cmd   = 1'b0;
    start_write = 1'b0;
    shift_addr  = 1'b0;
    shift_data  = 1'b0;
    latch_rd    = 1'b0;
    load_reply  = 1'b0;
    reply_next  = 8'h00;
    cnt_clr     = 1'b0;
    cnt_inc     = 1'b0;
    tx_wr_c     = 1'b0;
    tx_data_c   = 8'h00;
    addr_c      = IDLE_ADDR;
    dout_c      = 32'h0;
    we_c        = 1'b0;
    case (state)
      IDLE: begin
        if (rx_valid) begin
          cnt_clr = 1'b1;
          if (rx_data == CMD_WRITE) begin
            state_next  = ADDR;
            start_cmd   = 1'b1;
            start_write = 1'b1;
          end else if (rx_data == CMD_READ) begin
            state_next = ADDR;
            start_cmd  = 1'b1;
          end else begin
            state_next = ACK;
            load_reply = 1'b1;
            reply_next = REPLY_BAD;
          end
        end
      end
      ADDR: begin
        if (rx_valid) begin
          shift_addr = 1'b1;
          cnt_inc    = 1'b1;
          if (byte_cnt == 2'd3) state_next = is_write ? DATA : RWAIT;
        end
      end
      DATA: begin
        if (rx_valid) begin
          shift_data = 1'b1;
          cnt_inc    = 1'b1;
          if (byte_cnt == 2'd3) state_next = WRITE;
        end
      end
      WRITE: begin
        addr_c     = addr_reg;
        dout_c     = data_reg;
        we_c       = 1'b1;
        state_next = ACK;
        load_reply = 1'b1;
        reply_next = REPLY_OK;
      end
      RWAIT: begin
        addr_c = addr_reg;
        // a strobe on the last counted cycle takes precedence over the timeout
        if (strobe_b) begin
          latch_rd   = 1'b1;
          state_next = SEND;
        end else if (timeout_hit) begin
          state_next = ACK;
          load_reply = 1'b1;
          reply_next = REPLY_TOUT;
        end
      end
      SEND: begin
        tx_wr_c = tx_ok;
        case (byte_cnt)
          2'd0:    tx_data_c = rd_word[31:24];
          2'd1:    tx_data_c = rd_word[23:16];
          2'd2:    tx_data_c = rd_word[15:8];
          default: tx_data_c = rd_word[7:0];
        endcase
        if (tx_ok) begin
          cnt_inc = 1'b1;
          if (byte_cnt == 2'd3) state_next = IDLE;
        end
      end
      ACK: begin
        tx_wr_c   = tx_ok;
        tx_data_c = reply;
        if (tx_ok) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      is_write <= 1'b0;
      addr_reg <= 32'h0;
      data_reg <= 32'h0;
      rd_word  <= 32'h0;
      byte_cnt <= 2'd0;
      reply    <= 8'h00;
      tx_gap   <= 1'b0;
      tcnt     <= 32'h0;
    end else begin
      tx_gap <= tx_wr_c;
      if (start_cmd)  is_write <= start_write;
      if (cnt_clr)      byte_cnt <= 2'd0;
      else if (cnt_inc) byte_cnt <= byte_cnt + 2'd1;
      if (shift_addr) addr_reg <= {addr_reg[23:0], rx_data};
      if (shift_data) data_reg <= {data_reg[23:0], rx_data};
      if (latch_rd)   rd_word  <= data_b_in;
      if (load_reply) reply    <= reply_next;
      tcnt <= (state == RWAIT) ? tcnt + 32'd1 : 32'h0;
    end
  end

  // outputs are forced to their idle values combinationally while rst is high
  assign tx_wr      = rst ? 1'b0      : tx_wr_c;
  assign tx_data    = rst ? 8'h00     : tx_data_c;
  assign addr_b     = rst ? IDLE_ADDR : addr_c;
  assign data_b_out = rst ? 32'h0     : dout_c;
  assign data_b_we  = rst ? 1'b0      : we_c;
  assign busy       = rst ? 1'b0      : (state != IDLE);

endmodule

// File: tb/tb_uart_dbg_master.sv
// Self-checking bench for uart_dbg_master: directed and randomized commands against a reply model.
// Define UART_DBG_TIMEOUT_EN for both files to exercise the read timeout path.
module tb_uart_dbg_master;

  localparam logic [31:0] IDLE_ADDR = 32'hFFFFFFFF;
  localparam int          TOUT      = 16;

  typedef logic [7:0] bq_t[$];

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        tx_busy;
  logic        tx_wr;
  logic [7:0]  tx_data;
  logic [31:0] addr_b;
  logic [31:0] data_b_out;
  logic        data_b_we;
  logic [31:0] data_b_in;
  logic        strobe_b;
  logic        busy;

  int passed = 0;
  int total  = 0;
  int viol   = 0;
  logic [7:0]  txq[$];
  logic [63:0] wrq[$];
  logic        prev_wr = 1'b0;

  uart_dbg_master #(.IDLE_ADDR(IDLE_ADDR), .TIMEOUT_CYCLES(TOUT)) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_busy(tx_busy), .tx_wr(tx_wr), .tx_data(tx_data),
    .addr_b(addr_b), .data_b_out(data_b_out), .data_b_we(data_b_we),
    .data_b_in(data_b_in), .strobe_b(strobe_b), .busy(busy)
  );

  always #5 clk = ~clk;

  // Observe outputs just before each rising edge; record traffic and protocol violations
  always @(negedge clk) begin
    #4;
    if (tx_wr === 1'b1) begin
      txq.push_back(tx_data);
      if (tx_busy) viol++;
      if (prev_wr) viol++;
    end
    prev_wr = (tx_wr === 1'b1);
    if (data_b_we === 1'b1) wrq.push_back({addr_b, data_b_out});
    if (busy === 1'b0 && (addr_b !== IDLE_ADDR || data_b_out !== 32'h0 || data_b_we !== 1'b0))
      viol++;
  end

  // Reply model: what the master must send back for a command
  function automatic bq_t model_reply(logic [7:0] cmd, logic [31:0] rdata, bit timed_out);
    bq_t q;
    q = {};
    if (cmd == 8'h57)      q.push_back(8'h4B);
    else if (cmd == 8'h52) begin
      if (timed_out) q.push_back(8'hEE);
      else for (int i = 0; i < 4; i++) q.push_back(8'(rdata >> (24 - 8 * i)));
    end else               q.push_back(8'h3F);
    return q;
  endfunction

  task automatic checkOutput(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic applyStimulus(logic [7:0] b);
    int gap;
    gap = $urandom_range(0, 2);
    repeat (gap) @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  task automatic send_word(logic [31:0] w);
    for (int i = 0; i < 4; i++) applyStimulus(8'(w >> (24 - 8 * i)));
  endtask

  task automatic wait_tx(int n, int budget, string tag);
    int k;
    k = 0;
    while (txq.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    checkOutput({tag, " tx count"}, txq.size(), n);
  endtask

  task automatic compare_tx(bq_t exp, string tag);
    for (int i = 0; i < exp.size(); i++)
      if (i < txq.size()) checkOutput($sformatf("%s byte%0d", tag, i), txq[i], exp[i]);
  endtask

  task automatic settle_idle(string tag, int ntx, int nwr);
    repeat (4) @(negedge clk);
    #1;
    checkOutput({tag, " busy"}, busy, 0);
    checkOutput({tag, " tx total"}, txq.size(), ntx);
    checkOutput({tag, " bus writes"}, wrq.size(), nwr);
  endtask

  task automatic do_write(logic [31:0] a, logic [31:0] d, string tag);
    txq.delete();
    wrq.delete();
    applyStimulus(8'h57);
    send_word(a);
    send_word(d);
    #1;
    checkOutput({tag, " we"}, data_b_we, 1);
    checkOutput({tag, " addr_b"}, addr_b, a);
    checkOutput({tag, " data_b_out"}, data_b_out, d);
    @(negedge clk);
    #1;
    checkOutput({tag, " we after"}, data_b_we, 0);
    wait_tx(1, 20, tag);
    compare_tx(model_reply(8'h57, 32'h0, 1'b0), tag);
    if (wrq.size() > 0) checkOutput({tag, " rec"}, wrq[0][63:32] ^ wrq[0][31:0], a ^ d);
    settle_idle(tag, 1, 1);
  endtask

  task automatic issue_read(logic [31:0] a, string tag);
    txq.delete();
    wrq.delete();
    applyStimulus(8'h52);
    send_word(a);
    #1;
    checkOutput({tag, " rwait addr_b"}, addr_b, a);
    checkOutput({tag, " rwait we"}, data_b_we, 0);
  endtask

  task automatic return_data(logic [31:0] w);
    strobe_b  = 1'b1;
    data_b_in = w;
    @(negedge clk);
    strobe_b  = 1'b0;
    data_b_in = $urandom;
  endtask

  task automatic do_read(logic [31:0] a, logic [31:0] w, int lat, string tag);
    issue_read(a, tag);
    repeat (lat) @(negedge clk);
    return_data(w);
    wait_tx(4, 40, tag);
    compare_tx(model_reply(8'h52, w, 1'b0), tag);
    settle_idle(tag, 4, 0);
  endtask

  task automatic do_bad(logic [7:0] b, string tag);
    txq.delete();
    wrq.delete();
    applyStimulus(b);
    wait_tx(1, 20, tag);
    compare_tx(model_reply(b, 32'h0, 1'b0), tag);
    settle_idle(tag, 1, 0);
  endtask

  initial begin
    logic [7:0]  b;
    logic [31:0] w;
    int          cnt;

    rst = 1'b1; rx_valid = 1'b1; rx_data = 8'h57; tx_busy = 1'b0;
    data_b_in = 32'h0; strobe_b = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("reset tx_wr", tx_wr, 0);
    checkOutput("reset tx_data", tx_data, 0);
    checkOutput("reset addr_b", addr_b, IDLE_ADDR);
    checkOutput("reset data_b_out", data_b_out, 0);
    checkOutput("reset we", data_b_we, 0);
    checkOutput("reset busy", busy, 0);
    rx_valid = 1'b0; strobe_b = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] directed write / read / bad command");
    do_write(32'h00010004, 32'h000000A5, "wr_directed");
    do_read(32'h00000010, 32'hDEADBEEF, 2, "rd_directed");
    do_bad(8'h41, "bad_directed");

    $display("[TB] randomized commands");
    for (int it = 0; it < 8; it++) begin
      case ($urandom_range(0, 2))
        0: do_write($urandom, $urandom, $sformatf("wr_rand%0d", it));
        1: do_read($urandom, $urandom, $urandom_range(0, 5), $sformatf("rd_rand%0d", it));
        default: begin
          b = 8'($urandom);
          while (b == 8'h57 || b == 8'h52) b = 8'($urandom);
          do_bad(b, $sformatf("bad_rand%0d", it));
        end
      endcase
    end

    $display("[TB] tx_busy held in SEND, byte dropped in RWAIT");
    w = $urandom;
    issue_read(32'hA0B0C0D0, "txbusy");
    applyStimulus(8'h57);
    tx_busy = 1'b1;
    return_data(w);
    repeat (50) @(negedge clk);
    checkOutput("txbusy no tx while busy", txq.size(), 0);
    tx_busy = 1'b0;
    wait_tx(4, 40, "txbusy");
    compare_tx(model_reply(8'h52, w, 1'b0), "txbusy");
    settle_idle("txbusy", 4, 0);

    $display("[TB] strobe outside RWAIT");
    txq.delete();
    wrq.delete();
    return_data(32'h12345678);
    settle_idle("stray strobe", 0, 0);

    $display("[TB] reset mid-command");
    txq.delete();
    wrq.delete();
    applyStimulus(8'h52);
    applyStimulus(8'h11);
    applyStimulus(8'h22);
    rst = 1'b1;
    @(negedge clk);
    #1;
    checkOutput("midrst busy", busy, 0);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    settle_idle("midrst", 0, 0);
    do_read(32'h00C0FFEE, $urandom, 1, "after_rst");

`ifdef UART_DBG_TIMEOUT_EN
    $display("[TB] read timeout");
    issue_read(32'h00000040, "tout");
    cnt = 0;
    while (addr_b === 32'h00000040 && cnt < 100) begin
      cnt++;
      @(negedge clk);
      #1;
    end
    checkOutput("tout rwait cycles", cnt, TOUT);
    checkOutput("tout addr_b idle", addr_b, IDLE_ADDR);
    wait_tx(1, 20, "tout");
    compare_tx(model_reply(8'h52, 32'h0, 1'b1), "tout");
    settle_idle("tout", 1, 0);

    w = $urandom;
    issue_read(32'h00000044, "tout_edge");
    repeat (TOUT - 1) @(negedge clk);
    return_data(w);
    wait_tx(4, 40, "tout_edge");
    compare_tx(model_reply(8'h52, w, 1'b0), "tout_edge");
    settle_idle("tout_edge", 4, 0);
`else
    $display("[TB] long read latency without timeout");
    do_read(32'h00000080, $urandom, 3 * TOUT, "long_wait");
`endif

    checkOutput("protocol invariants", viol, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
